acq_ctrl: RTL
=============

ACQ_CTRL -- requirements
Module: acq_ctrl

Interface
REQ-001 SHALL have parameter FRST_CYC, default 8, cycles fifo_rst is held high.
REQ-002 SHALL have parameter FWAIT_CYC, default 16, recovery cycles after fifo_rst falls before arming.
REQ-003 SHALL have parameter CAPT_CYC, default 1_000_000, capture window length in cycles (legal range 1..2^20).
REQ-004 SHALL have ports: clk_100  in  1  sole clock; rising edge only.
REQ-005 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  capture request, clk_100 domain; rising edge is the event.
REQ-007 SHALL have ports: abort  in  1  level, clk_100 domain; cancels an acquisition in progress.
REQ-008 SHALL have ports: trig  in  1  asynchronous external trigger; used only with ACQ_TRIG_EN.
REQ-009 SHALL have ports: fifo_full  in  1  and  fifo_empty  in  1, both asynchronous FIFO flags.
REQ-010 SHALL have ports: fifo_rst  out  1  FIFO reset; en_adc  out  1  ADC sample gate; wr_en  out  1  FIFO write enable.
REQ-011 SHALL have ports: busy  out  1  high in every state except IDLE; over_re  out  1  one-cycle completion pulse; ovf  out  1  sticky overflow; capt_cnt  out  20  samples counted in the current window.

Function
REQ-012 SHALL implement the states IDLE, FRST, FWAIT, ARM, CAPT, DRAIN and DONE, with all outputs registered.
REQ-013 SHALL detect a start rising edge with a registered copy of start; an edge accepted at clock k puts the block in FRST from clock k+1, with fifo_rst=1 and ovf and capt_cnt cleared.
REQ-014 SHALL ignore start edges in every state except IDLE, and SHALL NOT queue them.
REQ-015 SHALL hold FRST for exactly FRST_CYC cycles, then move to FWAIT with fifo_rst=0.
REQ-016 SHALL hold FWAIT for exactly FWAIT_CYC cycles, then move to ARM.
REQ-017 SHALL, in CAPT, drive en_adc=1 and wr_en=1 and increment capt_cnt by one per cycle.
REQ-018 SHALL leave CAPT for DRAIN in the cycle after capt_cnt reaches CAPT_CYC, with capt_cnt frozen at that value.
REQ-019 SHALL, if synced fifo_full is 1 in CAPT, set ovf, drop en_adc and wr_en on the next cycle and go to DRAIN; if full and the window end coincide, ovf is set and the exit is the same.
REQ-020 SHALL stay in DRAIN, with en_adc=wr_en=0, until synced fifo_empty is 1, then go to DONE.
REQ-021 SHALL drive over_re=1 for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL, on abort=1 in any state other than IDLE, go to IDLE on the next clock with fifo_rst=en_adc=wr_en=0 and no over_re; ovf and capt_cnt keep their values.
REQ-023 SHALL give abort priority over every other transition in the same cycle.
REQ-024 SHALL pass fifo_full, fifo_empty and trig through two-flop synchronizers, adding 2 cycles of latency to each.

Reset
REQ-025 SHALL, while rst_n=0 at a clk_100 edge, force state=IDLE, all outputs=0, capt_cnt=0, internal counters=0 and synchronizer flops=0.
REQ-026 SHALL honour reset taken mid-acquisition the same as reset from idle, with no over_re pulse.

Configuration
REQ-027 SHALL use the macro ACQ_TRIG_EN; when it is defined, ARM waits for a rising edge of synced trig before entering CAPT, and abort still exits.
REQ-028 SHALL, without ACQ_TRIG_EN, make ARM last exactly one cycle before CAPT, with the trig port present but unused.

Structure
REQ-029 SHALL define the state encoding (typedef) and the default FRST_CYC, FWAIT_CYC and CAPT_CYC constants in the shared package acq_pkg.
REQ-030 SHALL instantiate a sub-module acq_sync, a parameterised-width two-flop synchronizer, once for {trig, fifo_full, fifo_empty}.

Verification (bench: FRST_CYC=8, FWAIT_CYC=16, CAPT_CYC=100)
REQ-031 SHALL check: start pulse, fifo_empty=1 -> fifo_rst high 8 cycles, wr_en high exactly 100 cycles, capt_cnt=100, one over_re pulse, ovf=0.
REQ-032 SHALL check: fifo_full driven high at capture cycle 40 -> ovf=1, wr_en low by cycle 43, DRAIN entered, over_re after fifo_empty rises.
REQ-033 SHALL check: abort at capture cycle 50 -> IDLE next clock, wr_en=0, busy=0, no over_re, capt_cnt holds about 50.
REQ-034 SHALL check: second start edge during CAPT -> ignored; exactly one over_re for the run.
REQ-035 SHALL check: rst_n low during FWAIT -> all outputs 0 next clock; a new start then runs a complete sequence.
REQ-036 SHALL check with ACQ_TRIG_EN defined: trig held low for 500 cycles -> busy=1, wr_en=0; trig rise -> wr_en high 3 cycles later, for 100 cycles.

Source files
------------

// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared state encoding, default timing constants and helpers for acq_ctrl
package acq_pkg;

  typedef logic [2:0] acq_state_t;

  localparam acq_state_t ST_IDLE  = 3'd0;
  localparam acq_state_t ST_FRST  = 3'd1;
  localparam acq_state_t ST_FWAIT = 3'd2;
  localparam acq_state_t ST_ARM   = 3'd3;
  localparam acq_state_t ST_CAPT  = 3'd4;
  localparam acq_state_t ST_DRAIN = 3'd5;
  localparam acq_state_t ST_DONE  = 3'd6;

  localparam int FRST_CYC_DEF  = 8;
  localparam int FWAIT_CYC_DEF = 16;
  localparam int CAPT_CYC_DEF  = 1_000_000;

  localparam int CAPT_CNT_W = 20;

  // A 2^20-cycle window overflows the 20-bit count by one, so hold at all-ones.
  function automatic logic [CAPT_CNT_W-1:0] sat_inc(input logic [CAPT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/acq_sync.sv
// rtl/acq_sync.sv - parameterised-width two-flop synchronizer
module acq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/acq_ctrl.sv
// rtl/acq_ctrl.sv - FIFO-reset / capture-window acquisition sequencer
// Define ACQ_TRIG_EN to make ARM wait for a rising edge of the synced trig input.
module acq_ctrl
  import acq_pkg::*;
#(
  parameter int FRST_CYC  = FRST_CYC_DEF,
  parameter int FWAIT_CYC = FWAIT_CYC_DEF,
  parameter int CAPT_CYC  = CAPT_CYC_DEF
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        trig,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        fifo_rst,
  output logic        en_adc,
  output logic        wr_en,
  output logic        busy,
  output logic        over_re,
  output logic        ovf,
  output logic [19:0] capt_cnt
);

  localparam int PH_MAX = (FRST_CYC > FWAIT_CYC) ? FRST_CYC : FWAIT_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]       FRST_LAST  = PH_W'(FRST_CYC - 1);
  localparam logic [PH_W-1:0]       FWAIT_LAST = PH_W'(FWAIT_CYC - 1);
  localparam logic [CAPT_CNT_W-1:0] CAPT_LAST  = CAPT_CNT_W'(CAPT_CYC - 1);

  logic [2:0] sync_in;
  logic [2:0] sync_out;
  logic       trig_s;
  logic       full_s;
  logic       empty_s;
  logic       arm_go;

  acq_sync #(
    .WIDTH(3)
  ) u_sync (
    .clk  (clk_100),
    .rst_n(rst_n),
    .d    (sync_in),
    .q    (sync_out)
  );

  assign sync_in                   = {trig, fifo_full, fifo_empty};
  assign {trig_s, full_s, empty_s} = sync_out;

`ifdef ACQ_TRIG_EN
  logic trig_prev_q;
  logic trig_prev_d;

  always_comb begin
    trig_prev_d = trig_s;
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      trig_prev_q <= 1'b0;
    end else begin
      trig_prev_q <= trig_prev_d;
    end
  end

  // A trigger already high on entry to ARM does not count; a fresh rise is needed.
  assign arm_go = trig_s & ~trig_prev_q;
`else
  logic unused_trig;
  assign unused_trig = trig_s;
  assign arm_go      = 1'b1;
`endif

  acq_state_t            state_q,    state_d;
  logic [PH_W-1:0]       ph_cnt_q,   ph_cnt_d;
  logic                  start_q,    start_d;
  logic                  fifo_rst_q, fifo_rst_d;
  logic                  en_adc_q,   en_adc_d;
  logic                  wr_en_q,    wr_en_d;
  logic                  busy_q,     busy_d;
  logic                  over_re_q,  over_re_d;
  logic                  ovf_q,      ovf_d;
  logic [CAPT_CNT_W-1:0] capt_cnt_q, capt_cnt_d;
  logic                  start_edge;
  logic                  capt_exit;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    start_d    = start;
    fifo_rst_d = fifo_rst_q;
    en_adc_d   = en_adc_q;
    wr_en_d    = wr_en_q;
    over_re_d  = 1'b0;
    ovf_d      = ovf_q;
    capt_cnt_d = capt_cnt_q;
    capt_exit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d    = ST_FRST;
          ph_cnt_d   = '0;
          fifo_rst_d = 1'b1;
          ovf_d      = 1'b0;
          capt_cnt_d = '0;
        end
      end
      ST_FRST: begin
        if (ph_cnt_q == FRST_LAST) begin
          state_d    = ST_FWAIT;
          ph_cnt_d   = '0;
          fifo_rst_d = 1'b0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      ST_FWAIT: begin
        if (ph_cnt_q == FWAIT_LAST) begin
          state_d  = ST_ARM;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      ST_ARM: begin
        if (arm_go) begin
          state_d  = ST_CAPT;
          en_adc_d = 1'b1;
          wr_en_d  = 1'b1;
        end
      end
      ST_CAPT: begin
        // Every CAPT cycle has wr_en high, so it is a sample even on the exit cycle.
        capt_cnt_d = sat_inc(capt_cnt_q);
        if (full_s) begin
          ovf_d     = 1'b1;
          capt_exit = 1'b1;
        end else if (capt_cnt_q == CAPT_LAST) begin
          capt_exit = 1'b1;
        end
        if (capt_exit) begin
          state_d  = ST_DRAIN;
          en_adc_d = 1'b0;
          wr_en_d  = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (empty_s) begin
          state_d   = ST_DONE;
          over_re_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        ph_cnt_d   = '0;
        fifo_rst_d = 1'b0;
        en_adc_d   = 1'b0;
        wr_en_d    = 1'b0;
      end
    endcase

    // Abort overrides everything, but leaves the result registers for inspection.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      ph_cnt_d   = '0;
      fifo_rst_d = 1'b0;
      en_adc_d   = 1'b0;
      wr_en_d    = 1'b0;
      over_re_d  = 1'b0;
      ovf_d      = ovf_q;
      capt_cnt_d = capt_cnt_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ph_cnt_q   <= '0;
      start_q    <= 1'b0;
      fifo_rst_q <= 1'b0;
      en_adc_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      over_re_q  <= 1'b0;
      ovf_q      <= 1'b0;
      capt_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      start_q    <= start_d;
      fifo_rst_q <= fifo_rst_d;
      en_adc_q   <= en_adc_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      over_re_q  <= over_re_d;
      ovf_q      <= ovf_d;
      capt_cnt_q <= capt_cnt_d;
    end
  end

  assign fifo_rst = fifo_rst_q;
  assign en_adc   = en_adc_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign over_re  = over_re_q;
  assign ovf      = ovf_q;
  assign capt_cnt = capt_cnt_q;

endmodule
